// File: rtl/bpsk_demodulator.sv
// rtl/bpsk_demodulator.sv - coherent BPSK correlator with one hard decision per carrier period
// Optional lock detector enabled by defining LOCK_DET_EN.
module bpsk_demodulator #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8,
    parameter int LOCK_THR   = 65536,
    parameter int LOCK_CNT   = 4
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic                             en,
    input  logic                             sync,
    input  logic [DATA_WIDTH-1:0]            signal_in,
    output logic                             s_out,
    output logic                             s_valid,
    output logic [DATA_WIDTH+ADDR_WIDTH:0]   corr,
    output logic                             lock
);

    localparam int C_W   = DATA_WIDTH + 1;
    localparam int ACC_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam logic [C_W-1:0] MIDSCALE = C_W'(1) << (DATA_WIDTH - 1);

    logic [ADDR_WIDTH-1:0]   ph;
    logic [ADDR_WIDTH-1:0]   p;
    logic signed [C_W-1:0]   c;
    logic signed [ACC_W-1:0] c_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] final_sum;
    logic                    first_ph;
    logic                    decide;

    // sync forces the current sample to phase 0, discarding any partial symbol
    always_comb begin
        p         = sync ? '0 : ph;
        c         = $signed({1'b0, signal_in} - MIDSCALE);
        c_ext     = {{(ACC_W-C_W){c[C_W-1]}}, c};
        term      = p[ADDR_WIDTH-1] ? -c_ext : c_ext;
        final_sum = acc + term;
        first_ph  = (p == '0);
        decide    = en && (p == '1);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            ph      <= '0;
            acc     <= '0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            corr    <= '0;
        end else begin
            s_valid <= decide;
            if (en) begin
                ph  <= p + 1'b1;
                acc <= first_ph ? term : final_sum;
            end
            if (decide) begin
                corr  <= final_sum;
                s_out <= final_sum[ACC_W-1];
            end
        end
    end

`ifdef LOCK_DET_EN
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(LOCK_THR);
    localparam logic signed [ACC_W-1:0] THR_NEG = -THR_POS;

    logic [CNT_W-1:0] strong_cnt;
    logic             strong;

    always_comb begin
        strong = (final_sum >= THR_POS) || (final_sum <= THR_NEG);
    end

    // a single weak decision drops lock immediately; reacquiring needs a full run
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            strong_cnt <= '0;
            lock       <= 1'b0;
        end else if (decide) begin
            if (strong) begin
                if (strong_cnt < CNT_W'(LOCK_CNT)) begin
                    strong_cnt <= strong_cnt + 1'b1;
                end
                lock <= (strong_cnt >= CNT_W'(LOCK_CNT - 1));
            end else begin
                strong_cnt <= '0;
                lock       <= 1'b0;
            end
        end
    end
`else
    // thresholds only matter to the detector; referenced here so they stay visible
    assign lock = 1'b0 & (LOCK_THR >= 0) & (LOCK_CNT >= 0);
`endif

endmodule

// File: tb/tb_bpsk_demodulator.sv
// tb/tb_bpsk_demodulator.sv - directed self-checking bench for bpsk_demodulator
module tb_bpsk_demodulator;

    logic        clk = 1'b0;
    logic        arst;
    logic        en;
    logic        sync;
    logic [11:0] signal_in;
    logic        s_out;
    logic        s_valid;
    logic [20:0] corr;
    logic        lock;

    int checks = 0;
    int errors = 0;

    bpsk_demodulator #(
        .DATA_WIDTH(12),
        .ADDR_WIDTH(8),
        .LOCK_THR  (65536),
        .LOCK_CNT  (4)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .en       (en),
        .sync     (sync),
        .signal_in(signal_in),
        .s_out    (s_out),
        .s_valid  (s_valid),
        .corr     (corr),
        .lock     (lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
        end
    endtask

    function automatic logic [31:0] corr_sx();
        return {{11{corr[20]}}, corr};
    endfunction

    // kind 0 midscale, 1 square phase 0, 2 square phase 180, 3/4 triangle carrier for bit 0/1
    function automatic logic [11:0] sample(input int kind, input int i);
        int m;
        int a;
        int v;
        m = i % 128;
        a = (m < 64) ? m * 30 : (128 - m) * 30;
        case (kind)
            0:       v = 2048;
            1:       v = (i < 128) ? 4095 : 0;
            2:       v = (i < 128) ? 0 : 4095;
            3:       v = (i < 128) ? 2048 + a : 2048 - a;
            default: v = (i < 128) ? 2048 - a : 2048 + a;
        endcase
        return 12'(v);
    endfunction

    task automatic step(input logic e, input logic s, input logic [11:0] v);
        en        = e;
        sync      = s;
        signal_in = v;
        @(posedge clk);
        #1;
    endtask

    // drives n samples of a symbol; optional en-low gap before sample gap_at
    task automatic run_symbol(input int kind, input bit do_sync, input int n,
                              input int gap_at, input int gap_len,
                              output int nvalid, output int valid_at);
        nvalid   = 0;
        valid_at = -1;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'b0, 1'b0, 12'(4095));
                    if (s_valid) begin
                        nvalid++;
                        valid_at = 1000 + g;
                    end
                end
            end
            step(1'b1, do_sync && (i == 0), sample(kind, i));
            if (s_valid) begin
                nvalid++;
                valid_at = i;
            end
        end
        en   = 1'b0;
        sync = 1'b0;
    endtask

    initial begin
        int  nv;
        int  va;
        bit  bad;
        bit  bits [8];
        logic exp_lock;

        arst      = 1'b0;
        en        = 1'b0;
        sync      = 1'b0;
        signal_in = '0;

        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            en        = 1'($urandom);
            sync      = 1'($urandom);
            signal_in = 12'($urandom);
            @(posedge clk);
            #1;
            if (s_out !== 1'b0 || s_valid !== 1'b0 || corr !== '0 || lock !== 1'b0) bad = 1'b1;
        end
        check("reset_outputs_quiet", 32'(bad), 32'd0);
        check("reset_corr", corr_sx(), 32'd0);
        en   = 1'b0;
        sync = 1'b0;
        #2;
        arst = 1'b1;
        @(posedge clk);
        #1;

        run_symbol(0, 1'b1, 256, -1, 0, nv, va);
        check("mid_nvalid", 32'(nv), 32'd1);
        check("mid_valid_at", 32'(va), 32'd255);
        check("mid_corr", corr_sx(), 32'd0);
        check("mid_s_out", 32'(s_out), 32'd0);

        run_symbol(1, 1'b1, 256, -1, 0, nv, va);
        check("pos_nvalid", 32'(nv), 32'd1);
        check("pos_corr", corr_sx(), 32'd524160);
        check("pos_s_out", 32'(s_out), 32'd0);

        run_symbol(2, 1'b0, 256, -1, 0, nv, va);
        check("neg_nvalid", 32'(nv), 32'd1);
        check("neg_corr", corr_sx(), -32'sd524160);
        check("neg_s_out", 32'(s_out), 32'd1);

        step(1'b0, 1'b0, 12'd0);
        check("held_s_valid_low", 32'(s_valid), 32'd0);
        check("held_corr", corr_sx(), -32'sd524160);

        run_symbol(1, 1'b0, 256, 60, 10, nv, va);
        check("gap_nvalid", 32'(nv), 32'd1);
        check("gap_valid_at", 32'(va), 32'd255);
        check("gap_corr", corr_sx(), 32'd524160);
        check("gap_s_out", 32'(s_out), 32'd0);

        run_symbol(1, 1'b0, 100, -1, 0, nv, va);
        check("drop_partial_nvalid", 32'(nv), 32'd0);
        run_symbol(2, 1'b1, 256, -1, 0, nv, va);
        check("drop_next_nvalid", 32'(nv), 32'd1);
        check("drop_next_valid_at", 32'(va), 32'd255);
        check("drop_next_corr", corr_sx(), -32'sd524160);

        run_symbol(2, 1'b0, 255, -1, 0, nv, va);
        check("lastph_partial_nvalid", 32'(nv), 32'd0);
        run_symbol(1, 1'b1, 256, -1, 0, nv, va);
        check("lastph_sync_nvalid", 32'(nv), 32'd1);
        check("lastph_sync_corr", corr_sx(), 32'd524160);

        bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            bits[k] = 1'($urandom);
        end
        run_symbol(0, 1'b1, 256, -1, 0, nv, va);
        check("pre_loop_lock", 32'(lock), 32'd0);
        for (int k = 0; k < 8; k++) begin
            run_symbol(bits[k] ? 4 : 3, 1'b0, 256, -1, 0, nv, va);
            check($sformatf("loop_nvalid_%0d", k), 32'(nv), 32'd1);
            check($sformatf("loop_bit_%0d", k), 32'(s_out), 32'(bits[k]));
            check($sformatf("loop_corr_%0d", k), corr_sx(), bits[k] ? -32'sd245760 : 32'd245760);
`ifdef LOCK_DET_EN
            exp_lock = (k >= 3);
`else
            exp_lock = 1'b0;
`endif
            check($sformatf("loop_lock_%0d", k), 32'(lock), 32'(exp_lock));
        end
        run_symbol(0, 1'b0, 256, -1, 0, nv, va);
        check("weak_nvalid", 32'(nv), 32'd1);
        check("weak_lock", 32'(lock), 32'd0);

        run_symbol(1, 1'b1, 128, -1, 0, nv, va);
        #2;
        arst = 1'b0;
        #2;
        check("async_reset_corr", corr_sx(), 32'd0);
        check("async_reset_s_out", 32'(s_out), 32'd0);
        arst = 1'b1;
        @(posedge clk);
        #1;
        run_symbol(1, 1'b0, 256, -1, 0, nv, va);
        check("post_reset_nvalid", 32'(nv), 32'd1);
        check("post_reset_corr", corr_sx(), 32'd524160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
